// File: rtl/cpu_pipeline_pkg.sv
// Shared types for the pipeline hazard scoreboard: stage record,
// forward-select encoding, depth helper and producer match function.
package cpu_pipeline_pkg;

  // Records carry register numbers at a fixed maximum width;
  // narrower register files zero-extend into it.
  localparam int REC_AW = 8;

  typedef struct packed {
    logic              valid;
    logic [REC_AW-1:0] rd;
    logic [REC_AW-1:0] rs1;
    logic [REC_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
    logic              wre;
    logic              is_load;
  } stage_rec_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_WB   = 2'd1,
    FWD_MEM  = 2'd2
  } fwd_sel_e;

  // E + MEM_LAT memory stages + W
  function automatic int stage_cnt(int mem_lat);
    return mem_lat + 2;
  endfunction

  function automatic logic rec_match(
    stage_rec_t        p,
    logic [REC_AW-1:0] src,
    logic              used,
    logic              zero_en
  );
    return p.valid & p.wre & used & (p.rd == src)
         & ~(zero_en & (p.rd == '0));
  endfunction

endpackage

// File: rtl/pipeline_hazard_scoreboard_fwd.sv
// operand_fwd_select: picks the ALU operand source for one E operand.
// Ports: E operand (valid/src/used), M[0] and W records in; select out.
module operand_fwd_select
  import cpu_pipeline_pkg::*;
#(
  parameter logic ZERO_EN = 1'b1
) (
  input  logic              e_valid_i,
  input  logic [REC_AW-1:0] src_i,
  input  logic              used_i,
  input  stage_rec_t        m0_i,
  input  stage_rec_t        w_i,
  output fwd_sel_e          sel_o
);

  logic rd_use;
  logic m0_hit;
  logic w_hit;

  assign rd_use = e_valid_i & used_i;

  // A load in M[0] has no data yet, so it can never feed the ALU.
  assign m0_hit = rec_match(m0_i, src_i, rd_use, ZERO_EN)
                & ~m0_i.is_load;
  assign w_hit  = rec_match(w_i, src_i, rd_use, ZERO_EN);

  always_comb begin
    sel_o = FWD_NONE;
    if (m0_hit) begin
      sel_o = FWD_MEM;
    end else if (w_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard/forwarding controller: shift-register scoreboard E,M[..],W.
// Ports: decode slot in; stall/flush/bubble, fwd selects, mask, count.
module pipeline_hazard_scoreboard
  import cpu_pipeline_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int NUM_REGS    = 16,
  parameter int MEM_LAT     = 1,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_valid,
  input  logic [REG_AW-1:0]   dec_rs1,
  input  logic [REG_AW-1:0]   dec_rs2,
  input  logic                dec_rs1_used,
  input  logic                dec_rs2_used,
  input  logic [REG_AW-1:0]   dec_rd,
  input  logic                dec_wre,
  input  logic                dec_is_load,
  input  logic                dec_is_branch,
  input  logic                branch_taken,
  output logic                stall,
  output logic                flush_fd,
  output logic                bubble_de,
  output logic [1:0]          fwd_sel_a,
  output logic [1:0]          fwd_sel_b,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    stall_count
);

  localparam int   SC  = stage_cnt(MEM_LAT);
  localparam logic ZEN = (ZERO_REG_EN != 0);

  // index 0 = E, k+1 = M[k], SC-1 = W
  stage_rec_t sb_q [SC];
  stage_rec_t sb_d [SC];
  stage_rec_t dec_rec;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [SC-1:0]    hz;
  fwd_sel_e         sel_a;
  fwd_sel_e         sel_b;

  always_comb begin
    dec_rec          = '0;
    dec_rec.valid    = dec_valid;
    dec_rec.rd       = REC_AW'(dec_rd);
    dec_rec.rs1      = REC_AW'(dec_rs1);
    dec_rec.rs2      = REC_AW'(dec_rs2);
    dec_rec.rs1_used = dec_rs1_used;
    dec_rec.rs2_used = dec_rs2_used;
    dec_rec.wre      = dec_wre;
    dec_rec.is_load  = dec_is_load;
  end

  // Q is where the producer sits when decode would be in E.
  for (genvar p = 0; p < SC; p++) begin : g_hz
    localparam int   Q     = p + 1;
    localparam logic NL_HZ = (Q >= 2) && (Q <= MEM_LAT);
    localparam logic LD_HZ = (Q < MEM_LAT + 1);
    localparam logic BR_HZ = (p <= MEM_LAT);
    logic hit;
    assign hit = rec_match(sb_q[p], dec_rec.rs1,
                           dec_rs1_used, ZEN)
               | rec_match(sb_q[p], dec_rec.rs2,
                           dec_rs2_used, ZEN);
    assign hz[p] = hit
                 & ((sb_q[p].is_load ? LD_HZ : NL_HZ)
                   | (dec_is_branch & BR_HZ));
  end

  assign stall     = reset & dec_valid & (|hz);
  assign bubble_de = stall;
  assign flush_fd  = reset & dec_valid & dec_is_branch
                   & branch_taken & ~stall;

  always_comb begin
    sb_d[0] = '0;
    if (dec_valid & ~stall & ~flush_fd) begin
      sb_d[0] = dec_rec;
    end
    for (int k = 1; k < SC; k++) begin
      sb_d[k] = sb_q[k-1];
    end
  end

  assign cnt_d = (stall && cnt_q != '1)
               ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_q  <= '{default: '0};
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < SC; k++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (sb_q[k].valid && sb_q[k].wre
            && sb_q[k].rd == REC_AW'(r)
            && !(ZEN && r == 0)) begin
          busy_mask[r] = 1'b1;
        end
      end
    end
  end

  operand_fwd_select #(.ZERO_EN(ZEN)) u_fwd_a (
    .e_valid_i (sb_q[0].valid),
    .src_i     (sb_q[0].rs1),
    .used_i    (sb_q[0].rs1_used),
    .m0_i      (sb_q[1]),
    .w_i       (sb_q[SC-1]),
    .sel_o     (sel_a)
  );

  operand_fwd_select #(.ZERO_EN(ZEN)) u_fwd_b (
    .e_valid_i (sb_q[0].valid),
    .src_i     (sb_q[0].rs2),
    .used_i    (sb_q[0].rs2_used),
    .m0_i      (sb_q[1]),
    .w_i       (sb_q[SC-1]),
    .sel_o     (sel_b)
  );

  assign fwd_sel_a   = sel_a;
  assign fwd_sel_b   = sel_b;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Bench for pipeline_hazard_scoreboard: MEM_LAT=1 and MEM_LAT=3 copies
// share decode inputs; each is checked against an in-flight list model.
module tb_pipeline_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_valid, d_u1, d_u2, d_wre, d_ld, d_br, d_tk;
  logic [3:0] d_rs1, d_rs2, d_rd;

  logic [1:0]  st, bub, fls;
  logic [1:0]  fa [2];
  logic [1:0]  fb [2];
  logic [15:0] bm [2];
  logic [15:0] sc [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_scoreboard #(.MEM_LAT(1)) u_l1 (
    .clk(clk), .reset(rst_n), .dec_valid(d_valid),
    .dec_rs1(d_rs1), .dec_rs2(d_rs2),
    .dec_rs1_used(d_u1), .dec_rs2_used(d_u2),
    .dec_rd(d_rd), .dec_wre(d_wre), .dec_is_load(d_ld),
    .dec_is_branch(d_br), .branch_taken(d_tk),
    .stall(st[0]), .flush_fd(fls[0]), .bubble_de(bub[0]),
    .fwd_sel_a(fa[0]), .fwd_sel_b(fb[0]),
    .busy_mask(bm[0]), .stall_count(sc[0])
  );

  pipeline_hazard_scoreboard #(.MEM_LAT(3)) u_l3 (
    .clk(clk), .reset(rst_n), .dec_valid(d_valid),
    .dec_rs1(d_rs1), .dec_rs2(d_rs2),
    .dec_rs1_used(d_u1), .dec_rs2_used(d_u2),
    .dec_rd(d_rd), .dec_wre(d_wre), .dec_is_load(d_ld),
    .dec_is_branch(d_br), .branch_taken(d_tk),
    .stall(st[1]), .flush_fd(fls[1]), .bubble_de(bub[1]),
    .fwd_sel_a(fa[1]), .fwd_sel_b(fb[1]),
    .busy_mask(bm[1]), .stall_count(sc[1])
  );

  // Reference model: list of in-flight instructions with their age
  // (cycles since entering E); age == pipeline position.
  typedef struct {
    bit         v;
    logic [3:0] rd, rs1, rs2;
    bit         u1, u2, wre, ld;
    int         age;
  } ins_t;

  ins_t fl [2][8];
  int   ml [2] = '{1, 3};
  int   cnt_m [2];
  bit   e_stall [2];
  bit   e_flush [2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit mt(ins_t x, logic [3:0] s, bit used);
    return x.v && x.wre && used && x.rd == s && x.rd != 4'd0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      cnt_m[i] = 0;
      for (int s = 0; s < 8; s++) fl[i][s].v = 0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      bit hz;
      logic [1:0] efa, efb;
      logic [15:0] eb;
      ins_t e, m0, w;
      hz = 0; eb = '0;
      e.v = 0; m0.v = 0; w.v = 0;
      for (int s = 0; s < 8; s++) begin
        if (fl[i][s].v) begin
          int p;
          bit hit;
          p = fl[i][s].age;
          hit = mt(fl[i][s], d_rs1, d_u1) || mt(fl[i][s], d_rs2, d_u2);
          if (hit) begin
            if (fl[i][s].ld ? (p + 1 < ml[i] + 1)
                            : (p + 1 >= 2 && p + 1 <= ml[i])) hz = 1;
            if (d_br && p <= ml[i]) hz = 1;
          end
          if (fl[i][s].wre && fl[i][s].rd != 4'd0) eb[fl[i][s].rd] = 1'b1;
          if (p == 0) e = fl[i][s];
          if (p == 1) m0 = fl[i][s];
          if (p == ml[i] + 1) w = fl[i][s];
        end
      end
      e_stall[i] = rst_n && d_valid && hz;
      e_flush[i] = rst_n && d_valid && d_br && d_tk && !e_stall[i];
      efa = 2'd0;
      if (mt(m0, e.rs1, e.v && e.u1) && !m0.ld) efa = 2'd2;
      else if (mt(w, e.rs1, e.v && e.u1)) efa = 2'd1;
      efb = 2'd0;
      if (mt(m0, e.rs2, e.v && e.u2) && !m0.ld) efb = 2'd2;
      else if (mt(w, e.rs2, e.v && e.u2)) efb = 2'd1;
      chk($sformatf("stall_l%0d", ml[i]), st[i], e_stall[i]);
      chk($sformatf("bubble_l%0d", ml[i]), bub[i], e_stall[i]);
      chk($sformatf("flush_l%0d", ml[i]), fls[i], e_flush[i]);
      chk($sformatf("fwd_a_l%0d", ml[i]), fa[i], efa);
      chk($sformatf("fwd_b_l%0d", ml[i]), fb[i], efb);
      chk($sformatf("busy_l%0d", ml[i]), bm[i], eb);
      chk($sformatf("count_l%0d", ml[i]), sc[i], cnt_m[i]);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        cnt_m[i] = 0;
        for (int s = 0; s < 8; s++) fl[i][s].v = 0;
      end else begin
        bit done;
        if (e_stall[i] && cnt_m[i] != 16'hFFFF) cnt_m[i]++;
        for (int s = 0; s < 8; s++) begin
          if (fl[i][s].v) begin
            fl[i][s].age++;
            if (fl[i][s].age > ml[i] + 1) fl[i][s].v = 0;
          end
        end
        done = 0;
        if (d_valid && !e_stall[i] && !e_flush[i]) begin
          for (int s = 0; s < 8; s++) begin
            if (!fl[i][s].v && !done) begin
              fl[i][s].v = 1;
              fl[i][s].rd = d_rd;
              fl[i][s].rs1 = d_rs1;
              fl[i][s].rs2 = d_rs2;
              fl[i][s].u1 = d_u1;
              fl[i][s].u2 = d_u2;
              fl[i][s].wre = d_wre;
              fl[i][s].ld = d_ld;
              fl[i][s].age = 0;
              done = 1;
            end
          end
        end
      end
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_rst(bit r);
    rst_n = r;
    if (!r) model_clear();
  endtask

  task automatic drv(bit v, logic [3:0] rs1, bit u1, logic [3:0] rs2,
                     bit u2, logic [3:0] rd, bit w, bit ld,
                     bit br, bit tk);
    d_valid = v; d_rs1 = rs1; d_u1 = u1; d_rs2 = rs2; d_u2 = u2;
    d_rd = rd; d_wre = w; d_ld = ld; d_br = br; d_tk = tk;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_rst();
    idle();
    set_rst(0);
    step();
    set_rst(1);
  endtask

  initial begin
    idle();
    set_rst(0);
    @(negedge clk);
    step();
    set_rst(1);
    step();

    // ALU producer forwarded from M[0], then from W
    do_rst();
    drv(1, 1, 1, 0, 0, 3, 1, 0, 0, 0); step();
    drv(1, 3, 1, 0, 0, 6, 1, 0, 0, 0); #1;
    chk("alu_nostall", st[0], 0); step();
    drv(1, 3, 1, 0, 0, 7, 1, 0, 0, 0); #1;
    chk("alu_fwd_mem", fa[0], 2); step();
    idle(); #1;
    chk("alu_fwd_wb", fa[0], 1); step();

    // load-use, one stall cycle then WB forward
    do_rst();
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); step();
    drv(1, 0, 0, 5, 1, 9, 1, 0, 0, 0); #1;
    chk("ld_stall", st[0], 1);
    chk("ld_bubble", bub[0], 1); step();
    #1; chk("ld_release", st[0], 0); step();
    idle(); #1;
    chk("ld_fwd_b", fb[0], 1);
    chk("ld_count", sc[0], 1); step();

    // MEM_LAT=3: producer in M[0] and M[1] stalls a dependent
    do_rst();
    drv(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); step();
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); step();
    drv(1, 2, 1, 0, 0, 8, 1, 0, 0, 0); #1;
    chk("l3_stall0", st[1], 1); step();
    #1; chk("l3_stall1", st[1], 1); step();
    #1; chk("l3_go", st[1], 0); step();
    idle(); #1;
    chk("l3_fwd_wb", fa[1], 1); step();

    // decode branch waits for producer to reach W, then flushes
    do_rst();
    drv(1, 0, 0, 0, 0, 4, 1, 0, 0, 0); step();
    drv(1, 4, 1, 0, 0, 0, 0, 0, 1, 1); #1;
    chk("br_stall_e", st[0], 1);
    chk("br_noflush_e", fls[0], 0); step();
    #1;
    chk("br_stall_m", st[0], 1);
    chk("br_noflush_m", fls[0], 0); step();
    #1;
    chk("br_go", st[0], 0);
    chk("br_flush", fls[0], 1); step();
    idle(); #1;
    chk("br_flush_pulse", fls[0], 0); step();

    // register 0 never hazards
    do_rst();
    drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); step();
    drv(1, 0, 1, 0, 1, 9, 1, 0, 0, 0); #1;
    chk("r0_stall", st[0], 0);
    chk("r0_busy", bm[0], 0); step();
    idle(); #1;
    chk("r0_fwd_a", fa[0], 0);
    chk("r0_fwd_b", fb[0], 0); step();

    // reset with writers in flight
    do_rst();
    drv(1, 0, 0, 0, 0, 1, 1, 1, 0, 0); step();
    drv(1, 1, 1, 0, 0, 2, 1, 0, 0, 0); step();
    step();
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); step();
    drv(1, 1, 1, 3, 1, 4, 1, 0, 0, 0);
    set_rst(0); #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", bm[i], 0);
      chk("rst_stall", st[i], 0);
      chk("rst_count", sc[i], 0);
    end
    step();
    set_rst(1);
    idle(); step();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_fwd_a", fa[i], 0);
      chk("rst_fwd_b", fb[i], 0);
    end
    step();

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(99) == 0) set_rst(0);
      else if (!rst_n) set_rst(1);
      drv($urandom_range(9) < 8,
          4'($urandom_range(5)), 1'($urandom_range(1)),
          4'($urandom_range(5)), 1'($urandom_range(1)),
          4'($urandom_range(5)), $urandom_range(3) != 0,
          $urandom_range(3) == 0, $urandom_range(4) == 0,
          1'($urandom_range(1)));
      step();
    end

    set_rst(1);
    idle();
    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
